mem_req_arbiter: RTL and testbench

- Sits between the processor core's fetch/memRead/memWrite request ports and a single-ported memory32-style backing store.
- Accepts three request streams over valid/ready handshakes and serialises them onto one memory port, one transaction outstanding at a time.
- Routes each read response back to the requester that issued it.
- Returns an error response if the memory fails to answer within a bounded time.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_select.sv | 57 +++++
 rtl/mem_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory request arbiter.
//   req_src_e   : which requester owns the outstanding transaction
//   arb_state_e : arbiter FSM states
//   mem_req_t   : latched downstream request (write flag, address, data)
//   wrap3       : modulo-3 reduction used by the rotating selector
// Build option: MEM_ARB_ROUND_ROBIN_EN selects rotating priority in mem_arb_select.
package mem_arb_pkg;

  // Width of the packed request struct; the top-level XLEN must match it.
  localparam int MEM_ARB_XLEN = 32;

  typedef enum logic [1:0] {SRC_NONE, SRC_FETCH, SRC_LOAD, SRC_STORE} req_src_e;
  typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_e;

  typedef struct packed {
    logic                    write;
    logic [MEM_ARB_XLEN-1:0] addr;
    logic [MEM_ARB_XLEN-1:0] data;
  } mem_req_t;

  // Reduce a value in 0..5 to 0..2.
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Request selector: one-hot grant among the three request valids.
//   grant[2] = store, grant[1] = load, grant[0] = fetch.
// Default build: fixed priority store > load > fetch, purely combinational.
// MEM_ARB_ROUND_ROBIN_EN: rotating priority pointer (CLK/RESET/advance ports
// exist only in this build); after each taken grant the source following the
// winner becomes highest priority.
module mem_arb_select
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic       CLK,
  input  logic       RESET,
  input  logic       advance,
`endif
  input  logic       fetch_valid,
  input  logic       load_valid,
  input  logic       store_valid,
  output logic [2:0] grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Priority list slots: 0 = store, 1 = load, 2 = fetch. ptr is the top slot.
  logic [1:0] ptr, ptr_nxt, idx;
  logic [2:0] lst, gnt_l;
  logic       found;

  assign lst = {fetch_valid, load_valid, store_valid};

  always_comb begin
    gnt_l   = '0;
    found   = 1'b0;
    ptr_nxt = ptr;
    idx     = '0;
    for (int i = 0; i < 3; i++) begin
      idx = wrap3({1'b0, ptr} + 3'(i));
      if (!found && lst[idx]) begin
        found      = 1'b1;
        gnt_l[idx] = 1'b1;
        ptr_nxt    = wrap3({1'b0, idx} + 3'd1);
      end
    end
  end

  // Slot order is the reverse of the grant bit order.
  assign grant = {gnt_l[0], gnt_l[1], gnt_l[2]};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                 ptr <= 2'd0;
    else if (advance && found) ptr <= ptr_nxt;
  end
`else
  assign grant = {store_valid,
                  load_valid & ~store_valid,
                  fetch_valid & ~load_valid & ~store_valid};
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Serialises fetch / load / store requests onto one memory port, one
// transaction outstanding, and routes read returns to their requester.
// Ports:
//   CLK, RESET            clock, async active-high reset
//   fetch_req_* / fetch_rsp_*   instruction fetch request / response (+err)
//   load_req_*  / load_rsp_*    data read request / response (+err)
//   store_req_* / store_rsp_valid  data write request / completion
//   mem_req_* / mem_rsp_*       downstream memory handshake and read return
//   busy                  FSM not in IDLE
// Parameters: XLEN (must equal MEM_ARB_XLEN), TIMEOUT (>= 1) cycles in RESP
// before an error response.
// Build option: MEM_ARB_ROUND_ROBIN_EN enables rotating request priority.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN    = MEM_ARB_XLEN,
  parameter int TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            fetch_req_valid,
  output logic            fetch_req_ready,
  input  logic [XLEN-1:0] fetch_req_addr,
  output logic            fetch_rsp_valid,
  output logic [XLEN-1:0] fetch_rsp_data,
  output logic            fetch_rsp_err,
  input  logic            load_req_valid,
  output logic            load_req_ready,
  input  logic [XLEN-1:0] load_req_addr,
  output logic            load_rsp_valid,
  output logic [XLEN-1:0] load_rsp_data,
  output logic            load_rsp_err,
  input  logic            store_req_valid,
  output logic            store_req_ready,
  input  logic [XLEN-1:0] store_req_addr,
  input  logic [XLEN-1:0] store_req_data,
  output logic            store_rsp_valid,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_write,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_data,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            busy
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  arb_state_e      state, state_nxt;
  req_src_e        src;
  mem_req_t        lat;
  logic [CW-1:0]   cnt;
  logic [2:0]      grant;
  logic            idle, take, timeout, done, wr_done;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  // Readys are gated by RESET so no output rises while reset is held.
  assign idle     = (state == IDLE) && !RESET;
  assign take     = idle && (grant != 3'b000);
  assign timeout  = (cnt == CW'(TIMEOUT - 1));
  assign done     = (state == RESP) && (mem_rsp_valid || timeout);
  assign wr_done  = (state == REQ) && mem_req_ready && lat.write;
  // Data beats timeout when both land in the same cycle.
  assign rsp_data = mem_rsp_valid ? mem_rsp_data : '0;
  assign rsp_err  = !mem_rsp_valid;

  mem_arb_select u_sel (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .CLK         (CLK),
    .RESET       (RESET),
    .advance     (take),
`endif
    .fetch_valid (fetch_req_valid),
    .load_valid  (load_req_valid),
    .store_valid (store_req_valid),
    .grant       (grant)
  );

  assign fetch_req_ready = idle & grant[0];
  assign load_req_ready  = idle & grant[1];
  assign store_req_ready = idle & grant[2];

  assign mem_req_valid = (state == REQ);
  assign mem_req_write = mem_req_valid & lat.write;
  assign mem_req_addr  = mem_req_valid ? lat.addr : '0;
  assign mem_req_data  = mem_req_valid ? lat.data : '0;
  assign busy          = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take)          state_nxt = REQ;
      REQ:     if (mem_req_ready) state_nxt = lat.write ? IDLE : RESP;
      RESP:    if (done)          state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state           <= IDLE;
      src             <= SRC_NONE;
      lat             <= '0;
      cnt             <= '0;
      fetch_rsp_valid <= 1'b0;
      fetch_rsp_data  <= '0;
      fetch_rsp_err   <= 1'b0;
      load_rsp_valid  <= 1'b0;
      load_rsp_data   <= '0;
      load_rsp_err    <= 1'b0;
      store_rsp_valid <= 1'b0;
    end else begin
      state <= state_nxt;

      if (take) begin
        src       <= grant[2] ? SRC_STORE : (grant[1] ? SRC_LOAD : SRC_FETCH);
        lat.write <= grant[2];
        lat.addr  <= grant[2] ? store_req_addr : (grant[1] ? load_req_addr : fetch_req_addr);
        lat.data  <= grant[2] ? store_req_data : '0;
      end else if (wr_done || done) begin
        src <= SRC_NONE;
      end

      // Counter restarts on read acceptance and saturates rather than wraps.
      if (state == REQ && mem_req_ready && !lat.write) cnt <= '0;
      else if (state == RESP && cnt != '1)             cnt <= cnt + CW'(1);

      // Response strobes are one cycle; data/err are zero outside the strobe.
      store_rsp_valid <= wr_done;
      fetch_rsp_valid <= done && (src == SRC_FETCH);
      fetch_rsp_data  <= (done && src == SRC_FETCH) ? rsp_data : '0;
      fetch_rsp_err   <= done && (src == SRC_FETCH) && rsp_err;
      load_rsp_valid  <= done && (src == SRC_LOAD);
      load_rsp_data   <= (done && src == SRC_LOAD) ? rsp_data : '0;
      load_rsp_err    <= done && (src == SRC_LOAD) && rsp_err;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model (priority
// order list, word memory, response delay / timeout rule).
module tb_mem_req_arbiter;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            fetch_req_valid, fetch_req_ready, fetch_rsp_valid, fetch_rsp_err;
  logic [XLEN-1:0] fetch_req_addr, fetch_rsp_data;
  logic            load_req_valid, load_req_ready, load_rsp_valid, load_rsp_err;
  logic [XLEN-1:0] load_req_addr, load_rsp_data;
  logic            store_req_valid, store_req_ready, store_rsp_valid;
  logic [XLEN-1:0] store_req_addr, store_req_data;
  logic            mem_req_valid, mem_req_ready, mem_req_write, mem_rsp_valid, busy;
  logic [XLEN-1:0] mem_req_addr, mem_req_data, mem_rsp_data;

  int checks = 0;
  int errors = 0;

  // Reference priority list of source ids (0 fetch, 1 load, 2 store).
  int order[3];
  // Reference memory contents.
  logic [31:0] mem_m [logic [31:0]];
  // Pending random requests per source id.
  logic [2:0]  pend;
  logic [31:0] paddr[3];
  logic [31:0] pdata[3];

  always #5 CLK = ~CLK;

  mem_req_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_req_addr(fetch_req_addr), .fetch_rsp_valid(fetch_rsp_valid),
    .fetch_rsp_data(fetch_rsp_data), .fetch_rsp_err(fetch_rsp_err),
    .load_req_valid(load_req_valid), .load_req_ready(load_req_ready),
    .load_req_addr(load_req_addr), .load_rsp_valid(load_rsp_valid),
    .load_rsp_data(load_rsp_data), .load_rsp_err(load_rsp_err),
    .store_req_valid(store_req_valid), .store_req_ready(store_req_ready),
    .store_req_addr(store_req_addr), .store_req_data(store_req_data),
    .store_rsp_valid(store_rsp_valid),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs;
    fetch_req_valid = 0; load_req_valid = 0; store_req_valid = 0;
    fetch_req_addr = '0; load_req_addr = '0; store_req_addr = '0; store_req_data = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  function automatic int pick(input logic [2:0] p);
    for (int i = 0; i < 3; i++) if (p[order[i]]) return order[i];
    return 0;
  endfunction

  // After a grant, rotating priority puts the source following the winner first.
  task automatic note_grant(input int w);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    int o[3];
    int p;
    p = 0;
    for (int i = 0; i < 3; i++) if (order[i] == w) p = i;
    for (int i = 0; i < 3; i++) o[i] = order[(p + 1 + i) % 3];
    order = o;
`else
    if (w < 0) order = '{2, 1, 0};
`endif
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : (a ^ 32'hA5A5_5A5A);
  endfunction

  task automatic test_reset;
    clear_inputs();
    RESET = 1;
    fetch_req_valid = 1; load_req_valid = 1; store_req_valid = 1;
    #3;
    checks++;
    if ({fetch_req_ready, load_req_ready, store_req_ready, mem_req_valid, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000",
        {fetch_req_ready, load_req_ready, store_req_ready, mem_req_valid, busy});
    end
    tick(); tick();
    checks++;
    if ({fetch_rsp_valid, load_rsp_valid, store_rsp_valid, fetch_rsp_err, load_rsp_err} !== 5'b0 ||
        mem_req_addr !== '0 || mem_req_data !== '0 || mem_req_write !== 1'b0) begin
      errors++; $display("FAIL reset_out: rsp %b addr %h want zeros",
        {fetch_rsp_valid, load_rsp_valid, store_rsp_valid}, mem_req_addr);
    end
    clear_inputs();
    RESET = 0;
    order = '{2, 1, 0};
    tick();
  endtask

  task automatic test_load_basic;
    load_req_valid = 1; load_req_addr = 32'h100; mem_req_ready = 1;
    #1;
    checks++;
    if ({store_req_ready, load_req_ready, fetch_req_ready} !== 3'b010) begin
      errors++; $display("FAIL load_ready: got %b want 010", {store_req_ready, load_req_ready, fetch_req_ready});
    end
    note_grant(1);
    tick();
    load_req_valid = 0;
    checks++;
    if (mem_req_valid !== 1 || mem_req_write !== 0 || mem_req_addr !== 32'h100) begin
      errors++; $display("FAIL load_memreq: valid %b write %b addr %h want 1 0 100",
        mem_req_valid, mem_req_write, mem_req_addr);
    end
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hDEAD_BEEF;
    checks++;
    if (load_rsp_valid !== 0) begin
      errors++; $display("FAIL load_early: got %b want 0", load_rsp_valid);
    end
    tick();
    mem_rsp_valid = 0;
    checks++;
    if (load_rsp_valid !== 1 || load_rsp_data !== 32'hDEAD_BEEF || load_rsp_err !== 0 || fetch_rsp_valid !== 0) begin
      errors++; $display("FAIL load_rsp: valid %b data %h err %b fetch %b want 1 deadbeef 0 0",
        load_rsp_valid, load_rsp_data, load_rsp_err, fetch_rsp_valid);
    end
    tick();
    checks++;
    if (load_rsp_valid !== 0 || busy !== 0) begin
      errors++; $display("FAIL load_pulse: valid %b busy %b want 0 0", load_rsp_valid, busy);
    end
  endtask

  // All sources held for n requests each; grant sequence follows the model order.
  task automatic test_arbitration(input int n);
    int left[3];
    int w;
    logic [2:0] p;
    left = '{n, n, n};
    fetch_req_addr = 32'h10; load_req_addr = 32'h20; store_req_addr = 32'h30;
    store_req_data = 32'hCAFE_0000; mem_req_ready = 1;
    while (left[0] + left[1] + left[2] > 0) begin
      p = {left[2] > 0, left[1] > 0, left[0] > 0};
      {store_req_valid, load_req_valid, fetch_req_valid} = p;
      #1;
      w = pick(p);
      note_grant(w);
      checks++;
      if ({store_req_ready, load_req_ready, fetch_req_ready} !== 3'(1 << w)) begin
        errors++; $display("FAIL arb_grant: got %b want %b", {store_req_ready, load_req_ready, fetch_req_ready}, 3'(1 << w));
      end
      tick();
      left[w]--;
      {store_req_valid, load_req_valid, fetch_req_valid} = {left[2] > 0, left[1] > 0, left[0] > 0};
      checks++;
      if (mem_req_valid !== 1 || mem_req_write !== (w == 2) || mem_req_addr !== 32'(32'h10 * (w + 1))) begin
        errors++; $display("FAIL arb_memreq: write %b addr %h want %b %h", mem_req_write, mem_req_addr, (w == 2), 32'(32'h10 * (w + 1)));
      end
      tick();
      if (w == 2) begin
        checks++;
        if (store_rsp_valid !== 1) begin
          errors++; $display("FAIL arb_store_rsp: got %b want 1", store_rsp_valid);
        end
      end else begin
        mem_rsp_valid = 1; mem_rsp_data = 32'h1000 + 32'(w);
        tick();
        mem_rsp_valid = 0;
        checks++;
        if ({load_rsp_valid, fetch_rsp_valid} !== 2'(1 << w) ||
            (w == 1 ? load_rsp_data : fetch_rsp_data) !== 32'h1000 + 32'(w)) begin
          errors++; $display("FAIL arb_read_rsp: valids %b want %b", {load_rsp_valid, fetch_rsp_valid}, 2'(1 << w));
        end
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout;
    int bad;
    fetch_req_valid = 1; fetch_req_addr = 32'h0; mem_req_ready = 1;
    #1;
    note_grant(0);
    tick();
    fetch_req_valid = 0;
    tick();
    mem_req_ready = 0;
    bad = 0;
    for (int k = 0; k < TIMEOUT; k++) begin
      if (fetch_rsp_valid !== 0 || busy !== 1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL timeout_wait: %0d early cycles want 0", bad);
    end
    checks++;
    if (fetch_rsp_valid !== 1 || fetch_rsp_err !== 1 || fetch_rsp_data !== '0 || busy !== 0) begin
      errors++; $display("FAIL timeout_rsp: valid %b err %b data %h busy %b want 1 1 0 0",
        fetch_rsp_valid, fetch_rsp_err, fetch_rsp_data, busy);
    end
    tick();
  endtask

  task automatic test_stall;
    store_req_valid = 1; store_req_addr = 32'h44; store_req_data = 32'h55AA;
    #1;
    note_grant(2);
    tick();
    store_req_valid = 0; load_req_valid = 1; load_req_addr = 32'h48;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (mem_req_valid !== 1 || mem_req_write !== 1 || mem_req_addr !== 32'h44 || mem_req_data !== 32'h55AA ||
          {store_req_ready, load_req_ready, fetch_req_ready} !== 3'b000) begin
        errors++; $display("FAIL stall_hold: cycle %0d valid %b addr %h data %h readys %b", c,
          mem_req_valid, mem_req_addr, mem_req_data, {store_req_ready, load_req_ready, fetch_req_ready});
      end
      tick();
    end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    #1;
    checks++;
    if (store_rsp_valid !== 1 || load_req_ready !== 1) begin
      errors++; $display("FAIL stall_b2b: store_rsp %b load_ready %b want 1 1", store_rsp_valid, load_req_ready);
    end
    note_grant(1);
    tick();
    load_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h4848;
    tick();
    mem_rsp_valid = 0;
    checks++;
    if (load_rsp_valid !== 1 || load_rsp_data !== 32'h4848) begin
      errors++; $display("FAIL stall_load: valid %b data %h want 1 4848", load_rsp_valid, load_rsp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    load_req_valid = 1; load_req_addr = 32'h200; mem_req_ready = 1;
    tick();
    load_req_valid = 0;
    tick();
    mem_req_ready = 0;
    RESET = 1;
    #1;
    checks++;
    if (busy !== 0 || mem_req_valid !== 0) begin
      errors++; $display("FAIL rstmid_async: busy %b memvalid %b want 0 0", busy, mem_req_valid);
    end
    tick();
    RESET = 0;
    order = '{2, 1, 0};
    mem_rsp_valid = 1; mem_rsp_data = 32'hBAD0_BAD0;
    tick();
    mem_rsp_valid = 0;
    tick();
    checks++;
    if ({fetch_rsp_valid, load_rsp_valid, store_rsp_valid} !== 3'b000 || busy !== 0) begin
      errors++; $display("FAIL rstmid_stray: rsp %b busy %b want 000 0", {fetch_rsp_valid, load_rsp_valid, store_rsp_valid}, busy);
    end
    load_req_valid = 1; load_req_addr = 32'h300; mem_req_ready = 1;
    #1;
    note_grant(1);
    tick();
    load_req_valid = 0;
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h1234_5678;
    tick();
    mem_rsp_valid = 0;
    checks++;
    if (load_rsp_valid !== 1 || load_rsp_data !== 32'h1234_5678 || load_rsp_err !== 0) begin
      errors++; $display("FAIL rstmid_next: valid %b data %h err %b", load_rsp_valid, load_rsp_data, load_rsp_err);
    end
    tick();
  endtask

  task automatic test_random(input int n);
    int w, d, stall;
    logic [31:0] exp_d;
    logic exp_err;
    pend = '0;
    for (int t = 0; t < n; t++) begin
      for (int s = 0; s < 3; s++)
        if (!pend[s] && $urandom_range(0, 1) == 1) begin
          pend[s] = 1; paddr[s] = 32'($urandom_range(0, 7)) << 2; pdata[s] = $urandom;
        end
      if (pend == 3'b000) begin
        pend[1] = 1; paddr[1] = 32'($urandom_range(0, 7)) << 2;
      end
      {store_req_valid, load_req_valid, fetch_req_valid} = pend;
      fetch_req_addr = paddr[0]; load_req_addr = paddr[1];
      store_req_addr = paddr[2]; store_req_data = pdata[2];
      mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rsp_data = $urandom;
      #1;
      w = pick(pend);
      note_grant(w);
      checks++;
      if ({store_req_ready, load_req_ready, fetch_req_ready} !== 3'(1 << w)) begin
        errors++; $display("FAIL rnd_grant: t %0d got %b want %b", t, {store_req_ready, load_req_ready, fetch_req_ready}, 3'(1 << w));
      end
      tick();
      pend[w] = 0;
      {store_req_valid, load_req_valid, fetch_req_valid} = pend;
      stall = $urandom_range(0, 3);
      for (int c = 0; c <= stall; c++) begin
        mem_req_ready = (c == stall);
        mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rsp_data = $urandom;
        #1;
        checks++;
        if (mem_req_valid !== 1 || mem_req_write !== (w == 2) || mem_req_addr !== paddr[w] ||
            (w == 2 && mem_req_data !== pdata[2]) || {store_req_ready, load_req_ready, fetch_req_ready} !== 3'b000) begin
          errors++; $display("FAIL rnd_memreq: t %0d write %b addr %h data %h want %b %h", t,
            mem_req_write, mem_req_addr, mem_req_data, (w == 2), paddr[w]);
        end
        tick();
      end
      mem_req_ready = 0; mem_rsp_valid = 0;
      if (w == 2) begin
        mem_m[paddr[2]] = pdata[2];
        checks++;
        if ({store_rsp_valid, load_rsp_valid, fetch_rsp_valid} !== 3'b100) begin
          errors++; $display("FAIL rnd_store_rsp: got %b want 100", {store_rsp_valid, load_rsp_valid, fetch_rsp_valid});
        end
      end else begin
        exp_d = rd_mem(paddr[w]);
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1) : $urandom_range(0, 2);
        for (int k = 0; k < TIMEOUT; k++) begin
          mem_rsp_valid = (k == d);
          mem_rsp_data = (k == d) ? exp_d : $urandom;
          #1;
          checks++;
          if ({store_rsp_valid, load_rsp_valid, fetch_rsp_valid} !== 3'b000 || busy !== 1) begin
            errors++; $display("FAIL rnd_wait: t %0d k %0d rsp %b busy %b", t, k,
              {store_rsp_valid, load_rsp_valid, fetch_rsp_valid}, busy);
          end
          tick();
          if (k == d) break;
        end
        mem_rsp_valid = 0;
        exp_err = (d >= TIMEOUT);
        checks++;
        if ({store_rsp_valid, load_rsp_valid, fetch_rsp_valid} !== 3'(1 << w) ||
            (w == 1 ? load_rsp_data : fetch_rsp_data) !== (exp_err ? 32'h0 : exp_d) ||
            (w == 1 ? load_rsp_err : fetch_rsp_err) !== exp_err) begin
          errors++; $display("FAIL rnd_read_rsp: t %0d src %0d d %0d rsp %b data %h want %h err %b", t, w, d,
            {store_rsp_valid, load_rsp_valid, fetch_rsp_valid}, (w == 1 ? load_rsp_data : fetch_rsp_data),
            (exp_err ? 32'h0 : exp_d), exp_err);
        end
      end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    order = '{2, 1, 0};
    test_reset();
    test_load_basic();
    test_arbitration(1);
    test_arbitration(6);
    test_timeout();
    test_stall();
    test_reset_mid();
    test_random(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
